// File: rtl/bitnet_pkg.sv
`default_nettype none
//============================================================================
// Package : bitnet_pkg
// Brief   : Shared types and width helpers for the fc sequencer datapath.
// Rev     : 1.0 - initial release
//============================================================================
package bitnet_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FWD_LAUNCH = 3'd1,
        ST_FWD_WAIT   = 3'd2,
        ST_RESULT     = 3'd3,
        ST_BK_LAUNCH  = 3'd4,
        ST_BK_WAIT    = 3'd5
    } fc_state_t;

    // Ceiling log2, never below 1 so it can size a register directly.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    function automatic int clog3(input int value);
        int     result;
        longint span;
        result = 0;
        span   = 1;
        for (int i = 0; i < 21; i++) begin
            if (span < longint'(value)) begin
                span   = span * 3;
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/popcount.sv
`default_nettype none
//============================================================================
// Module : popcount
// Brief  : Combinational count of set bits in an N-bit vector.
// Rev    : 1.0 - initial release
//============================================================================
module popcount
    import bitnet_pkg::*;
#(
    parameter int N = 27
) (
    input  logic [N-1:0]          i_bits,
    output logic [clog2(N+1)-1:0] o_count
);

    localparam int c_cnt_w = clog2(N + 1);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < N; i++) begin
            o_count = o_count + c_cnt_w'(i_bits[i]);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fc_sequencer.sv
`default_nettype none
//============================================================================
// Module : fc_sequencer
// Brief  : Launches fc forward/backward passes per sample and returns result.
// Rev    : 1.0 - initial release
//============================================================================
module fc_sequencer
    import bitnet_pkg::*;
#(
    parameter int N       = 27,
    parameter int TIMEOUT = 64,
    parameter int OSC_DIV = 4,
    parameter int COUNT_W = 16
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0]          in_data,
    input  logic [N-1:0]          in_target,
    input  logic                  in_train,
    output logic [N-1:0]          fin,
    output logic [N-1:0]          bin,
    output logic                  fd_prop,
    output logic                  bk_prop,
    input  logic                  fd_prop_done,
    input  logic                  bk_prop_done,
    input  logic [N-1:0]          fout,
    output logic                  oscillator,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0]          out_data,
    output logic [clog2(N+1)-1:0] out_err,
    output logic                  busy,
    output logic                  timeout_err,
    output logic [COUNT_W-1:0]    sample_count
);

    localparam int c_err_w  = clog2(N + 1);
    localparam int c_wait_w = clog2(TIMEOUT + 1);
    localparam int c_osc_w  = clog2(OSC_DIV + 1);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT - 1);
    localparam logic [c_osc_w-1:0]  c_osc_last  = c_osc_w'(OSC_DIV - 1);

    fc_state_t           r_state;
    logic                r_train;
    logic [c_wait_w-1:0] r_wait_cnt;
    logic [c_osc_w-1:0]  r_osc_cnt;
    logic [N-1:0]        w_diff;
    logic [c_err_w-1:0]  w_err;

    // bin holds the captured target, so the mismatch is taken against it.
    assign w_diff = fout ^ bin;

    popcount #(
        .N (N)
    ) u_popcount (
        .i_bits  (w_diff),
        .o_count (w_err)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state      <= ST_IDLE;
            r_train      <= 1'b0;
            r_wait_cnt   <= '0;
            r_osc_cnt    <= '0;
            in_ready     <= 1'b1;
            fin          <= '0;
            bin          <= '0;
            fd_prop      <= 1'b0;
            bk_prop      <= 1'b0;
            oscillator   <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_err      <= '0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            sample_count <= '0;
        end else begin
            fd_prop <= 1'b0;
            bk_prop <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        fin      <= in_data;
                        bin      <= in_target;
                        r_train  <= in_train;
                        fd_prop  <= 1'b1;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        r_state  <= ST_FWD_LAUNCH;
                    end
                end
                ST_FWD_LAUNCH: begin
                    r_wait_cnt <= '0;
                    r_state    <= ST_FWD_WAIT;
                end
                ST_FWD_WAIT: begin
                    // done is tested first so it wins on the last wait cycle
                    if (fd_prop_done) begin
                        out_data  <= fout;
                        out_err   <= w_err;
                        out_valid <= 1'b1;
                        r_state   <= ST_RESULT;
                    end else if (r_wait_cnt == c_wait_last) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        in_ready    <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_wait_w'(1);
                    end
                end
                ST_RESULT: begin
                    if (out_ready) begin
                        out_valid    <= 1'b0;
                        sample_count <= sample_count + COUNT_W'(1);
                        if (r_train) begin
                            bk_prop <= 1'b1;
                            r_state <= ST_BK_LAUNCH;
                        end else begin
                            busy     <= 1'b0;
                            in_ready <= 1'b1;
                            r_state  <= ST_IDLE;
                        end
                    end
                end
                ST_BK_LAUNCH: begin
                    r_wait_cnt <= '0;
                    r_osc_cnt  <= '0;
                    r_state    <= ST_BK_WAIT;
                end
                ST_BK_WAIT: begin
                    if (bk_prop_done) begin
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        r_state  <= ST_IDLE;
                    end else if (r_wait_cnt == c_wait_last) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        in_ready    <= 1'b1;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_wait_w'(1);
                        if (r_osc_cnt == c_osc_last) begin
                            oscillator <= ~oscillator;
                            r_osc_cnt  <= '0;
                        end else begin
                            r_osc_cnt <= r_osc_cnt + c_osc_w'(1);
                        end
                    end
                end
                default: begin
                    busy     <= 1'b0;
                    in_ready <= 1'b1;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fc_sequencer.sv
`default_nettype none
//============================================================================
// Module : tb_fc_sequencer
// Brief  : Directed self-checking bench for fc_sequencer.
// Rev    : 1.0 - initial release
//============================================================================
module tb_fc_sequencer;

    localparam int N  = 27;
    localparam int EW = 5;

    logic          clk_in = 1'b0;
    logic          rst_in, in_valid, in_train, fd_prop_done, bk_prop_done, out_ready;
    logic [N-1:0]  in_data, in_target, fout;
    logic          in_ready, fd_prop, bk_prop, oscillator, out_valid, busy, timeout_err;
    logic [N-1:0]  fin, bin, out_data;
    logic [EW-1:0] out_err;
    logic [15:0]   sample_count;

    logic          wr_in_ready, wr_fd_prop, wr_bk_prop, wr_oscillator, wr_out_valid;
    logic          wr_busy, wr_timeout_err;
    logic [N-1:0]  wr_fin, wr_bin, wr_out_data;
    logic [EW-1:0] wr_out_err;
    logic [3:0]    wr_sample_count;

    int          total = 0;
    int          bad   = 0;
    int          n_bk  = 0;
    int          n_ov  = 0;
    logic [15:0] e_cnt;
    logic        e_osc;

    fc_sequencer #(.N(N), .TIMEOUT(64), .OSC_DIV(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_target(in_target), .in_train(in_train),
        .fin(fin), .bin(bin), .fd_prop(fd_prop), .bk_prop(bk_prop),
        .fd_prop_done(fd_prop_done), .bk_prop_done(bk_prop_done), .fout(fout),
        .oscillator(oscillator), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err), .busy(busy),
        .timeout_err(timeout_err), .sample_count(sample_count)
    );

    // Narrow-counter twin sharing all stimulus, used to observe counter wrap.
    fc_sequencer #(.N(N), .TIMEOUT(64), .OSC_DIV(4), .COUNT_W(4)) dut_wrap (
        .clk_in(clk_in), .rst_in(rst_in), .in_valid(in_valid), .in_ready(wr_in_ready),
        .in_data(in_data), .in_target(in_target), .in_train(in_train),
        .fin(wr_fin), .bin(wr_bin), .fd_prop(wr_fd_prop), .bk_prop(wr_bk_prop),
        .fd_prop_done(fd_prop_done), .bk_prop_done(bk_prop_done), .fout(fout),
        .oscillator(wr_oscillator), .out_valid(wr_out_valid), .out_ready(out_ready),
        .out_data(wr_out_data), .out_err(wr_out_err), .busy(wr_busy),
        .timeout_err(wr_timeout_err), .sample_count(wr_sample_count)
    );

    always #5 clk_in = ~clk_in;

    always @(negedge clk_in) begin
        if (bk_prop === 1'b1) n_bk++;
        if (out_valid === 1'b1) n_ov++;
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic infer_fast(input logic [N-1:0] d, input logic [N-1:0] t,
                              input logic [N-1:0] fo, output logic ok,
                              output logic [N-1:0] od, output logic [EW-1:0] oe);
        int guard;
        ok = 1'b0; od = '0; oe = '0;
        in_data = d; in_target = t; in_train = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0; fd_prop_done = 1'b1; fout = fo;
        guard = 0;
        while (out_valid !== 1'b1 && guard < 8) begin
            tick;
            guard++;
        end
        fd_prop_done = 1'b0;
        if (out_valid === 1'b1) begin
            ok = 1'b1; od = out_data; oe = out_err;
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_in = 1'b0;
        tick; tick;
        total++;
        if ({in_ready, busy, fd_prop, bk_prop, out_valid, oscillator, timeout_err} !== 7'b1000000) begin
            bad++;
            $display("FAIL reset_flags: got %b want 1000000",
                     {in_ready, busy, fd_prop, bk_prop, out_valid, oscillator, timeout_err});
        end
        total++;
        if (sample_count !== 16'd0 || out_data !== '0 || out_err !== '0 || fin !== '0 || bin !== '0) begin
            bad++;
            $display("FAIL reset_data: cnt=%0d data=%h err=%0d fin=%h bin=%h want all 0",
                     sample_count, out_data, out_err, fin, bin);
        end
        rst_in = 1'b1;
        tick;
        total++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: in_ready=%b busy=%b want 1 0", in_ready, busy);
        end
        e_cnt = 16'd0;
        e_osc = 1'b0;
    endtask

    task automatic test_inference;
        int bk0;
        bk0 = n_bk;
        in_data = 27'h1; in_target = 27'h1; in_train = 1'b0; in_valid = 1'b1;
        tick;
        total++;
        if (fd_prop !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL inf_launch: fd_prop=%b busy=%b in_ready=%b want 1 1 0", fd_prop, busy, in_ready);
        end
        total++;
        if (fin !== 27'h1 || bin !== 27'h1) begin
            bad++;
            $display("FAIL inf_capture: fin=%h bin=%h want 1 1", fin, bin);
        end
        in_valid = 1'b0; in_data = 27'h7FFFFFF;
        tick;
        total++;
        if (fd_prop !== 1'b0 || fin !== 27'h1) begin
            bad++;
            $display("FAIL inf_pulse: fd_prop=%b fin=%h want 0 1", fd_prop, fin);
        end
        tick; tick; tick;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL inf_early_valid: out_valid=%b want 0", out_valid);
        end
        fd_prop_done = 1'b1; fout = 27'h3;
        tick;
        fd_prop_done = 1'b0; fout = '0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 27'h3 || out_err !== 5'd1) begin
            bad++;
            $display("FAIL inf_result: valid=%b data=%h err=%0d want 1 3 1", out_valid, out_data, out_err);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        e_cnt++;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || sample_count !== e_cnt) begin
            bad++;
            $display("FAIL inf_handshake: valid=%b busy=%b ready=%b cnt=%0d want 0 0 1 %0d",
                     out_valid, busy, in_ready, sample_count, e_cnt);
        end
        tick; tick;
        total++;
        if (n_bk != bk0) begin
            bad++;
            $display("FAIL inf_no_bk: bk_prop cycles=%0d want 0", n_bk - bk0);
        end
    endtask

    task automatic test_back_to_back;
        in_data = 27'h0000ABC; in_target = 27'h0; in_train = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0; fd_prop_done = 1'b1; fout = 27'h00000FF;
        tick; tick;
        fd_prop_done = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 27'h00000FF || out_err !== 5'd8) begin
            bad++;
            $display("FAIL b2b_first: valid=%b data=%h err=%0d want 1 ff 8", out_valid, out_data, out_err);
        end
        out_ready = 1'b1; in_valid = 1'b1; in_data = 27'h1234567; in_target = 27'h7654321;
        tick;
        e_cnt++;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || fin !== 27'h0000ABC || sample_count !== e_cnt) begin
            bad++;
            $display("FAIL b2b_gap: ready=%b valid=%b fin=%h cnt=%0d want 1 0 abc %0d",
                     in_ready, out_valid, fin, sample_count, e_cnt);
        end
        tick;
        out_ready = 1'b0; in_valid = 1'b0;
        total++;
        if (fd_prop !== 1'b1 || fin !== 27'h1234567 || bin !== 27'h7654321) begin
            bad++;
            $display("FAIL b2b_accept: fd_prop=%b fin=%h bin=%h want 1 1234567 7654321", fd_prop, fin, bin);
        end
        fd_prop_done = 1'b1; fout = 27'h7654321;
        tick; tick;
        fd_prop_done = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 27'h7654321 || out_err !== 5'd0) begin
            bad++;
            $display("FAIL b2b_second: valid=%b data=%h err=%0d want 1 7654321 0", out_valid, out_data, out_err);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        e_cnt++;
    endtask

    task automatic test_training;
        int bk0;
        bk0 = n_bk;
        in_data = 27'h2AAAAAA; in_target = 27'h0000001; in_train = 1'b1; in_valid = 1'b1;
        tick;
        in_valid = 1'b0; fd_prop_done = 1'b1; fout = 27'h0000003;
        tick; tick;
        fd_prop_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== 27'h3 || out_err !== 5'd1) begin
                bad++;
                $display("FAIL train_hold[%0d]: valid=%b data=%h err=%0d want 1 3 1", i, out_valid, out_data, out_err);
            end
            fout = 27'h5555555 ^ 27'(i);
            tick;
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        e_cnt++;
        total++;
        if (bk_prop !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || sample_count !== e_cnt) begin
            bad++;
            $display("FAIL train_bk_launch: bk=%b busy=%b valid=%b cnt=%0d want 1 1 0 %0d",
                     bk_prop, busy, out_valid, sample_count, e_cnt);
        end
        tick;
        for (int j = 0; j < 7; j++) begin
            total++;
            if (oscillator !== (e_osc ^ ((j / 4) % 2 == 1)) || bk_prop !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL train_osc[%0d]: osc=%b bk=%b busy=%b want %b 0 1",
                         j, oscillator, bk_prop, busy, e_osc ^ ((j / 4) % 2 == 1));
            end
            if (j == 6) bk_prop_done = 1'b1;
            tick;
        end
        bk_prop_done = 1'b0;
        e_osc = ~e_osc;
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || oscillator !== e_osc) begin
            bad++;
            $display("FAIL train_done: busy=%b ready=%b osc=%b want 0 1 %b", busy, in_ready, oscillator, e_osc);
        end
        tick; tick; tick;
        total++;
        if (oscillator !== e_osc || n_bk - bk0 != 1) begin
            bad++;
            $display("FAIL train_osc_hold: osc=%b bk_cycles=%0d want %b 1", oscillator, n_bk - bk0, e_osc);
        end
    endtask

    task automatic test_coincidence;
        in_data = 27'h0000010; in_target = 27'h0; in_train = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        repeat (63) tick;
        total++;
        if (busy !== 1'b1 || out_valid !== 1'b0 || timeout_err !== 1'b0 || oscillator !== e_osc) begin
            bad++;
            $display("FAIL coin_wait64: busy=%b valid=%b tmo=%b osc=%b want 1 0 0 %b",
                     busy, out_valid, timeout_err, oscillator, e_osc);
        end
        fd_prop_done = 1'b1; fout = 27'h0000010;
        tick;
        fd_prop_done = 1'b0;
        total++;
        if (out_valid !== 1'b1 || timeout_err !== 1'b0 || out_data !== 27'h10 || out_err !== 5'd1) begin
            bad++;
            $display("FAIL coin_result: valid=%b tmo=%b data=%h err=%0d want 1 0 10 1",
                     out_valid, timeout_err, out_data, out_err);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        e_cnt++;
        total++;
        if (timeout_err !== 1'b0 || sample_count !== e_cnt || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL coin_after: tmo=%b cnt=%0d ready=%b want 0 %0d 1", timeout_err, sample_count, in_ready, e_cnt);
        end
    endtask

    task automatic test_timeout;
        int           ov0;
        logic         ok;
        logic [N-1:0] od;
        logic [EW-1:0] oe;
        ov0 = n_ov;
        in_data = 27'h0000777; in_target = 27'h0; in_train = 1'b0; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        repeat (63) tick;
        total++;
        if (busy !== 1'b1 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL tmo_wait64: busy=%b tmo=%b want 1 0", busy, timeout_err);
        end
        tick;
        total++;
        if (timeout_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL tmo_fire: tmo=%b busy=%b ready=%b valid=%b want 1 0 1 0",
                     timeout_err, busy, in_ready, out_valid);
        end
        tick; tick;
        total++;
        if (n_ov != ov0 || sample_count !== e_cnt) begin
            bad++;
            $display("FAIL tmo_no_valid: valid_cycles=%0d cnt=%0d want 0 %0d", n_ov - ov0, sample_count, e_cnt);
        end
        infer_fast(27'h3, 27'h0, 27'h3, ok, od, oe);
        e_cnt++;
        total++;
        if (ok !== 1'b1 || timeout_err !== 1'b1 || oe !== 5'd2) begin
            bad++;
            $display("FAIL tmo_sticky: ok=%b tmo=%b err=%0d want 1 1 2", ok, timeout_err, oe);
        end
    endtask

    task automatic test_reset_mid_wait;
        int bk0;
        in_data = 27'h0000042; in_target = 27'h0000042; in_train = 1'b1; in_valid = 1'b1;
        tick;
        in_valid = 1'b0; fd_prop_done = 1'b1; fout = 27'h0000042;
        tick; tick;
        fd_prop_done = 1'b0; out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        e_cnt++;
        tick; tick; tick;
        total++;
        if (busy !== 1'b1 || oscillator !== e_osc) begin
            bad++;
            $display("FAIL rst_pre: busy=%b osc=%b want 1 %b", busy, oscillator, e_osc);
        end
        rst_in = 1'b0;
        tick;
        total++;
        if (busy !== 1'b0 || oscillator !== 1'b0 || in_ready !== 1'b1 || bk_prop !== 1'b0 ||
            fd_prop !== 1'b0 || out_valid !== 1'b0 || timeout_err !== 1'b0 || sample_count !== 16'd0) begin
            bad++;
            $display("FAIL rst_abort: busy=%b osc=%b ready=%b bk=%b fd=%b valid=%b tmo=%b cnt=%0d want 0 0 1 0 0 0 0 0",
                     busy, oscillator, in_ready, bk_prop, fd_prop, out_valid, timeout_err, sample_count);
        end
        rst_in = 1'b1;
        e_cnt = 16'd0;
        e_osc = 1'b0;
        bk0 = n_bk;
        bk_prop_done = 1'b1; fd_prop_done = 1'b1;
        tick; tick;
        bk_prop_done = 1'b0; fd_prop_done = 1'b0;
        total++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || oscillator !== 1'b0 || out_valid !== 1'b0 || n_bk != bk0) begin
            bad++;
            $display("FAIL rst_stray_done: busy=%b ready=%b osc=%b valid=%b bk_cycles=%0d want 0 1 0 0 0",
                     busy, in_ready, oscillator, out_valid, n_bk - bk0);
        end
    endtask

    task automatic test_popcount;
        logic [N-1:0]  tg [4];
        logic [N-1:0]  fo [4];
        logic [EW-1:0] ex [4];
        logic          ok;
        logic [N-1:0]  od;
        logic [EW-1:0] oe;
        tg[0] = 27'h5A5A5A5; fo[0] = ~tg[0];      ex[0] = 5'd27;
        tg[1] = 27'h0;       fo[1] = 27'h0F0F0F0; ex[1] = 5'd12;
        tg[2] = 27'h7FFFFFF; fo[2] = 27'h7FFFFFF; ex[2] = 5'd0;
        tg[3] = 27'h4000000; fo[3] = 27'h0000001; ex[3] = 5'd2;
        for (int i = 0; i < 4; i++) begin
            infer_fast(27'h0000100, tg[i], fo[i], ok, od, oe);
            e_cnt++;
            total++;
            if (ok !== 1'b1 || oe !== ex[i] || od !== fo[i] || sample_count !== e_cnt) begin
                bad++;
                $display("FAIL popcount[%0d]: ok=%b err=%0d data=%h cnt=%0d want 1 %0d %h %0d",
                         i, ok, oe, od, sample_count, ex[i], fo[i], e_cnt);
            end
        end
    endtask

    task automatic test_wrap;
        logic          ok;
        logic [N-1:0]  od, t, fo;
        logic [EW-1:0] oe;
        for (int i = 0; i < 20; i++) begin
            t  = N'($urandom);
            fo = N'($urandom);
            infer_fast(N'($urandom), t, fo, ok, od, oe);
            e_cnt++;
            total++;
            if (ok !== 1'b1 || sample_count !== e_cnt || wr_sample_count !== e_cnt[3:0] ||
                oe !== EW'($countones(t ^ fo)) || wr_busy !== 1'b0) begin
                bad++;
                $display("FAIL wrap[%0d]: ok=%b cnt=%0d narrow=%0d err=%0d busy2=%b want 1 %0d %0d %0d 0",
                         i, ok, sample_count, wr_sample_count, oe, wr_busy, e_cnt, e_cnt[3:0],
                         $countones(t ^ fo));
            end
        end
    endtask

    initial begin
        rst_in = 1'b0; in_valid = 1'b0; in_train = 1'b0; fd_prop_done = 1'b0;
        bk_prop_done = 1'b0; out_ready = 1'b0; in_data = '0; in_target = '0; fout = '0;
        e_cnt = 16'd0; e_osc = 1'b0;
        test_reset();
        test_inference();
        test_back_to_back();
        test_training();
        test_coincidence();
        test_timeout();
        test_reset_mid_wait();
        test_popcount();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fc_sequencer.md
FC_SEQUENCER -- requirements
Module: fc_sequencer

Interface
REQ-001 Parameter N, default 27, meaning the fc width in bits.
REQ-002 Parameter TIMEOUT, default 64, meaning the maximum cycles spent waiting for a done pulse.
REQ-003 Parameter OSC_DIV, default 4, meaning oscillator half-period in cycles.
REQ-004 clk_in  input  1  the single clock; all logic is clocked on its rising edge.
REQ-005 rst_in  input  1  synchronous, active-low reset.
REQ-006 in_valid/in_ready  input/output  1/1  sample handshake.
REQ-007 in_data, in_target  input  N each  forward input and desired output.
REQ-008 in_train  input  1  run backward propagation for this sample.
REQ-009 fin, bin  output  N each  drive the fc forward and backward inputs.
REQ-010 fd_prop, bk_prop  output  1 each  one-cycle launch pulses to the fc.
REQ-011 fd_prop_done, bk_prop_done, fout  input  1, 1, N  status and result from the fc.
REQ-012 oscillator  output  1  stochastic-update clock to the fc.
REQ-013 out_valid/out_ready  output/input  1/1  result handshake.
REQ-014 out_data, out_err  output  N, clog2(N+1)  fc output and popcount(fout XOR target).
REQ-015 busy, timeout_err, sample_count  output  1, 1, 16  status signals.

Function
REQ-016 The block SHALL use the states IDLE, FWD_LAUNCH, FWD_WAIT, RESULT, BK_LAUNCH and BK_WAIT.
REQ-017 In IDLE: in_ready=1; when in_valid=1, capture in_data, in_target and in_train, then go to FWD_LAUNCH.
REQ-018 FWD_LAUNCH: fd_prop=1 for exactly this cycle, then go to FWD_WAIT.
REQ-019 In FWD_WAIT: on fd_prop_done=1, register fout into out_data and the mismatch popcount into out_err, then go to RESULT.
REQ-020 In RESULT: out_valid=1 with out_data and out_err held stable; on out_ready=1, go to BK_LAUNCH if train was captured, else to IDLE.
REQ-021 BK_LAUNCH: bk_prop=1 for one cycle, then go to BK_WAIT; in BK_WAIT, on bk_prop_done=1, go to IDLE.
REQ-022 fin SHALL equal the captured in_data and bin the captured in_target from the capture cycle until the next capture.
REQ-023 Minimum latency: out_valid SHALL rise 2 cycles after fd_prop_done is first sampled high relative to launch; back-to-back inference SHALL accept the next sample in the cycle after the output handshake plus one.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 The wait counter SHALL clear on entry to FWD_WAIT or BK_WAIT; if it reaches TIMEOUT without a done pulse, set timeout_err and go to IDLE (no out_valid on a forward timeout).
REQ-026 When done and the final timeout cycle coincide, done SHALL win.
REQ-027 timeout_err SHALL be sticky until reset.
REQ-028 fd_prop_done and bk_prop_done SHALL be ignored outside their wait states.
REQ-029 oscillator SHALL toggle every OSC_DIV cycles only while in BK_WAIT, and hold its level elsewhere.
REQ-030 sample_count SHALL increment on each output handshake and wrap from 65535 to 0.
REQ-031 out_err width rule: clog2(N+1) bits, which is 5 for N=27; it SHALL never overflow.

Reset
REQ-032 With rst_in=0 at a clock edge, the block SHALL be in IDLE with all outputs 0 except in_ready=1.
REQ-033 Reset in any state, including mid-wait, SHALL abort without emitting fd_prop, bk_prop or out_valid in the following cycle.

Structure
REQ-034 The state enum type and the clog2/clog3 helper functions SHALL live in the shared bitnet package.
REQ-035 One sub-module, popcount (parameter N, purely combinational), SHALL compute out_err.

Verification
REQ-036 Inference: in_data=27'h1, target=27'h1, train=0, done 4 cycles after fd_prop, fout=27'h3 -> out_valid with out_data=27'h3, out_err=1; no bk_prop; sample_count=1.
REQ-037 Training: train=1, out_ready held low 5 cycles then high -> out_valid held stable; bk_prop pulses once; oscillator toggles every 4 cycles until bk_prop_done, then holds.
REQ-038 Timeout: fd_prop_done never asserted -> after 64 wait cycles, timeout_err=1, state IDLE, in_ready=1, no out_valid.
REQ-039 Coincidence: done on the 64th wait cycle -> result produced, timeout_err stays 0.
REQ-040 Reset: rst_in=0 during BK_WAIT -> next cycle busy=0, oscillator=0, in_ready=1; a stray bk_prop_done in IDLE is ignored.
REQ-041 Wrap and popcount: 65536 inferences -> sample_count=0; fout=~target -> out_err=27.
